fix_msg_builder: RTL and testbench

Serializes outbound FIX session messages (Logon, Logout, Heartbeat, ResendRequest) into a byte stream. It sits between the session manager's create-message request and the TOE transmit path. It accepts one request per handshake and emits the header, body and trailer fields with computed BodyLength(9) and CheckSum(10). It is the transmit-side counterpart of the received-message processor.

---
 rtl/fix_msg_builder.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_fix_msg_builder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_msg_builder.sv
// fix_msg_builder: turns a session-manager create-message request into a FIX 4.2
// byte stream (Logon, Logout, Heartbeat, ResendRequest) on a valid/ready link,
// filling in BodyLength(9) and CheckSum(10) on the fly.
// Build option: define FIX_MSG_QUEUE_EN to park one request that arrives while a
// message is in flight; without it such requests are dropped.
module fix_msg_builder #(
    parameter int          VALUE_WIDTH = 128,
    parameter int          SIZE        = 5,
    parameter logic [63:0] SENDER_ID   = "FPGAFIX1",
    parameter int          HB_INT      = 30
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   initiate_msg_i,
    input  logic [3:0]             msg_type_i,
    input  logic [VALUE_WIDTH-1:0] target_comp_id_i,
    input  logic [SIZE-1:0]        s_v_target_comp_id_i,
    input  logic [19:0]            seq_num_i,
    input  logic [19:0]            begin_seq_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    input  logic                   tx_ready_i,
    output logic                   tx_last_o,
    output logic                   busy_o,
    output logic                   drop_o,
    output logic                   msg_done_o
);

    localparam logic [3:0]  MSG_LOGON     = 4'h1;
    localparam logic [3:0]  MSG_LOGOUT    = 4'h2;
    localparam logic [3:0]  MSG_HEARTBEAT = 4'h3;
    localparam logic [3:0]  MSG_RESEND    = 4'h4;
    localparam int          MAX_BYTES     = VALUE_WIDTH / 8;
    localparam logic [7:0]  SOH           = 8'h01;
    localparam logic [71:0] BEGIN_STR     = "8=FIX.4.2";

    typedef enum logic [2:0] {IDLE, CONV, HDR, BODY, TRAIL} state_t;

    typedef struct packed {
        logic [3:0]             msgType;
        logic [VALUE_WIDTH-1:0] target;
        logic [SIZE-1:0]        len;
        logic [19:0]            seqNum;
        logic [19:0]            beginSeq;
    } req_t;

    state_t                 state_q;
    logic [3:0]             msgType_q;
    logic [VALUE_WIDTH-1:0] target_q;
    logic [SIZE-1:0]        len_q;
    logic [43:0]            seqConv_q;
    logic [43:0]            begConv_q;
    logic [4:0]             cnt_q;
    logic [9:0]             idx_q;
    logic [7:0]             sum_q;
    logic [7:0]             txData_q;
    logic                   txValid_q;
    logic                   txLast_q;
    logic                   busy_q;
    logic                   drop_q;
    logic                   done_q;

    req_t       reqIn;
    req_t       launchReq;
    logic       reqOk;
    logic       launch;
    logic       dropNow;
    logic [9:0] nextIdx;
    logic [7:0] txData_d;
    logic [7:0] typeChar;
    int         extraLen;
    int         bodyLen;
    int         ni;
    int         r;
    int         e;
    int         tr;

`ifdef FIX_MSG_QUEUE_EN
    req_t hold_q;
    logic holdValid_q;
    logic captureHold;
    logic launchFromHold;
`endif

    // ASCII digit k (0 = hundreds) of a value below 1000
    function automatic logic [7:0] decChar(input int value, input int k);
        int place;
        place = (k == 0) ? 100 : ((k == 1) ? 10 : 1);
        return 8'h30 + 8'((value / place) % 10);
    endfunction

    // ASCII digit k (0 = most significant) of a finished 6-digit conversion
    function automatic logic [7:0] bcdChar(input logic [43:0] conv, input int k);
        return 8'h30 + {4'h0, conv[43-4*k -: 4]};
    endfunction

    // One double-dabble iteration: BCD in [43:20], binary shifting out of [19:0]
    function automatic logic [43:0] dabbleStep(input logic [43:0] s);
        logic [43:0] t;
        t = s;
        for (int i = 0; i < 6; i++) begin
            if (t[20+4*i +: 4] >= 4'd5) t[20+4*i +: 4] = t[20+4*i +: 4] + 4'd3;
        end
        return t << 1;
    endfunction

    assign reqIn = {msg_type_i, target_comp_id_i, s_v_target_comp_id_i, seq_num_i, begin_seq_i};

    // Screen an incoming request for anything the serializer cannot express
    always_comb begin
        reqOk = (msg_type_i inside {MSG_LOGON, MSG_LOGOUT, MSG_HEARTBEAT, MSG_RESEND})
              && (s_v_target_comp_id_i != '0)
              && (32'(s_v_target_comp_id_i) <= 32'(MAX_BYTES))
              && (seq_num_i <= 20'd999999)
              && (begin_seq_i <= 20'd999999);
    end

    // Decide whether this cycle launches a message, parks a request, or discards one
    always_comb begin
        launch    = 1'b0;
        dropNow   = 1'b0;
        launchReq = reqIn;
`ifdef FIX_MSG_QUEUE_EN
        captureHold    = 1'b0;
        launchFromHold = 1'b0;
        if (initiate_msg_i && !reqOk) dropNow = 1'b1;
        if (state_q == IDLE) begin
            if (holdValid_q) begin
                launch         = 1'b1;
                launchFromHold = 1'b1;
                launchReq      = hold_q;
                captureHold    = initiate_msg_i && reqOk;
            end else if (initiate_msg_i && reqOk) begin
                launch = 1'b1;
            end
        end else if (initiate_msg_i && reqOk) begin
            if (holdValid_q) dropNow = 1'b1;
            else             captureHold = 1'b1;
        end
`else
        if (initiate_msg_i) begin
            if (reqOk && state_q == IDLE) launch = 1'b1;
            else                          dropNow = 1'b1;
        end
`endif
    end

    // Message geometry and the type letter for the latched request
    always_comb begin
        case (msgType_q)
            MSG_LOGON:  begin typeChar = "A"; extraLen = 13; end
            MSG_LOGOUT: begin typeChar = "5"; extraLen = 0;  end
            MSG_RESEND: begin typeChar = "2"; extraLen = 14; end
            default:    begin typeChar = "0"; extraLen = 0;  end
        endcase
        bodyLen = 31 + int'(len_q) + extraLen;
    end

    // Byte generator: the character that follows the one currently on tx_data_o
    always_comb begin
        nextIdx  = idx_q + 10'd1;
        ni       = int'(nextIdx);
        r        = ni - 16;
        e        = r - (31 + int'(len_q));
        tr       = ni - (16 + bodyLen);
        txData_d = SOH;
        if (ni < 9)                        txData_d = BEGIN_STR[71-8*ni -: 8];
        else if (ni == 10)                 txData_d = "9";
        else if (ni == 11)                 txData_d = "=";
        else if (ni >= 12 && ni < 15)      txData_d = decChar(bodyLen, ni - 12);
        else if (ni < 16)                  txData_d = SOH;
        else if (r == 0 || r == 5)         txData_d = "3";
        else if (r == 1)                   txData_d = "5";
        else if (r == 2 || r == 7)         txData_d = "=";
        else if (r == 3)                   txData_d = typeChar;
        else if (r == 6 || r == 15)        txData_d = "4";
        else if (r >= 8 && r < 14)         txData_d = bcdChar(seqConv_q, r - 8);
        else if (r == 16)                  txData_d = "9";
        else if (r == 17 || r == 29)       txData_d = "=";
        else if (r >= 18 && r < 26)        txData_d = SENDER_ID[63-8*(r-18) -: 8];
        else if (r == 27)                  txData_d = "5";
        else if (r == 28)                  txData_d = "6";
        else if (r >= 30 && e < 0)         txData_d = (e == -1) ? SOH : target_q[8*(r-30) +: 8];
        else if (e >= 0 && e < extraLen) begin
            if (msgType_q == MSG_LOGON) begin
                case (e)
                    0:        txData_d = "9";
                    1, 7:     txData_d = "8";
                    2, 8:     txData_d = "=";
                    3, 6:     txData_d = "0";
                    5:        txData_d = "1";
                    9, 10, 11: txData_d = decChar(HB_INT, e - 9);
                    default:  txData_d = SOH;
                endcase
            end else begin
                case (e)
                    0:        txData_d = "7";
                    1, 11:    txData_d = "=";
                    9:        txData_d = "1";
                    10:       txData_d = "6";
                    12:       txData_d = "0";
                    8, 13:    txData_d = SOH;
                    default:  txData_d = bcdChar(begConv_q, e - 2);
                endcase
            end
        end
        else if (tr == 0)                  txData_d = "1";
        else if (tr == 1)                  txData_d = "0";
        else if (tr == 2)                  txData_d = "=";
        else if (tr >= 3 && tr < 6)        txData_d = decChar(int'(sum_q), tr - 3);
    end

    // Main FSM: latch, convert, then stream with a registered valid/ready stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            msgType_q <= '0;
            target_q  <= '0;
            len_q     <= '0;
            seqConv_q <= '0;
            begConv_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            txData_q  <= '0;
            txValid_q <= 1'b0;
            txLast_q  <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef FIX_MSG_QUEUE_EN
            hold_q      <= '0;
            holdValid_q <= 1'b0;
`endif
        end else begin
            drop_q <= dropNow;
            done_q <= 1'b0;
`ifdef FIX_MSG_QUEUE_EN
            if (captureHold) begin
                hold_q      <= reqIn;
                holdValid_q <= 1'b1;
            end else if (launchFromHold) begin
                holdValid_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        msgType_q <= launchReq.msgType;
                        target_q  <= launchReq.target;
                        len_q     <= launchReq.len;
                        seqConv_q <= {24'd0, launchReq.seqNum};
                        begConv_q <= {24'd0, launchReq.beginSeq};
                        cnt_q     <= '0;
                        sum_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    seqConv_q <= dabbleStep(seqConv_q);
                    begConv_q <= dabbleStep(begConv_q);
                    cnt_q     <= cnt_q + 5'd1;
                    if (cnt_q == 5'd19) begin
                        state_q   <= HDR;
                        idx_q     <= '0;
                        txData_q  <= BEGIN_STR[71:64];
                        txValid_q <= 1'b1;
                        txLast_q  <= 1'b0;
                    end
                end
                default: begin
                    if (txValid_q && tx_ready_i) begin
                        if (int'(idx_q) < 16 + bodyLen) sum_q <= sum_q + txData_q;
                        if (txLast_q) begin
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            txValid_q <= 1'b0;
                            txLast_q  <= 1'b0;
                            txData_q  <= '0;
                            done_q    <= 1'b1;
                        end else begin
                            idx_q    <= nextIdx;
                            txData_q <= txData_d;
                            txLast_q <= (ni == 22 + bodyLen);
                            if (ni == 16)                state_q <= BODY;
                            else if (ni == 16 + bodyLen) state_q <= TRAIL;
                        end
                    end
                end
            endcase
        end
    end

    assign tx_data_o  = txData_q;
    assign tx_valid_o = txValid_q;
    assign tx_last_o  = txLast_q;
    assign busy_o     = busy_q;
    assign drop_o     = drop_q;
    assign msg_done_o = done_q;

endmodule

// File: tb/tb_fix_msg_builder.sv
// tb_fix_msg_builder: table-driven bench for fix_msg_builder with a byte scoreboard
// fed by a string-based FIX message model.
module tb_fix_msg_builder;

    localparam logic [3:0] LOGON     = 4'h1;
    localparam logic [3:0] LOGOUT    = 4'h2;
    localparam logic [3:0] HEARTBEAT = 4'h3;
    localparam logic [3:0] RESEND    = 4'h4;
    localparam logic [127:0] TGT_BRKR = 128'h524B5242;
    localparam logic [127:0] TGT_8    = 128'h3837363534333231;
    localparam logic [127:0] TGT_16   = 128'h46454443424139383736353433323130;

    logic         clk = 1'b0;
    logic         rst;
    logic         initiate_msg_i;
    logic [3:0]   msg_type_i;
    logic [127:0] target_comp_id_i;
    logic [4:0]   s_v_target_comp_id_i;
    logic [19:0]  seq_num_i;
    logic [19:0]  begin_seq_i;
    logic [7:0]   tx_data_o;
    logic         tx_valid_o;
    logic         tx_ready_i;
    logic         tx_last_o;
    logic         busy_o;
    logic         drop_o;
    logic         msg_done_o;

    always #5 clk = ~clk;

    fix_msg_builder dut (
        .clk                  (clk),
        .rst                  (rst),
        .initiate_msg_i       (initiate_msg_i),
        .msg_type_i           (msg_type_i),
        .target_comp_id_i     (target_comp_id_i),
        .s_v_target_comp_id_i (s_v_target_comp_id_i),
        .seq_num_i            (seq_num_i),
        .begin_seq_i          (begin_seq_i),
        .tx_data_o            (tx_data_o),
        .tx_valid_o           (tx_valid_o),
        .tx_ready_i           (tx_ready_i),
        .tx_last_o            (tx_last_o),
        .busy_o               (busy_o),
        .drop_o               (drop_o),
        .msg_done_o           (msg_done_o)
    );

    typedef struct {
        logic [3:0]   mtype;
        logic [127:0] tgt;
        logic [4:0]   len;
        logic [19:0]  seq;
        logic [19:0]  beg;
        int           readyMode;
        bit           expDrop;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       expQ[$];
    vec_t       vecs[11];
    int         total = 0;
    int         bad = 0;
    int         cyc, firstValidCyc, finalXferCyc, xferCount, doneCount, dropCount;
    int         expBodyLen, curReadyMode, expDone;
    bit         sawValid, sawBusy;
    logic       prevValid, prevReady;
    logic [7:0] prevData;
    vec_t       inj;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic [3:0] t, input logic [127:0] g, input logic [4:0] l,
                                   input logic [19:0] s, input logic [19:0] b, input int rm, input bit d);
        vec_t v;
        v.mtype = t; v.tgt = g; v.len = l; v.seq = s; v.beg = b; v.readyMode = rm; v.expDrop = d;
        return v;
    endfunction

    // Independent model: build the whole message as text and queue its bytes
    task automatic pushMessage(input vec_t v);
        string tgt, tc, body, msg;
        int    sum;
        exp_t  ex;
        tgt = "";
        for (int i = 0; i < int'(v.len); i++) tgt = {tgt, $sformatf("%c", v.tgt[8*i +: 8])};
        case (v.mtype)
            LOGON:   tc = "A";
            LOGOUT:  tc = "5";
            RESEND:  tc = "2";
            default: tc = "0";
        endcase
        body = $sformatf("35=%s%c34=%06d%c49=FPGAFIX1%c56=%s%c", tc, 8'd1, v.seq, 8'd1, 8'd1, tgt, 8'd1);
        if (v.mtype == LOGON)  body = {body, $sformatf("98=0%c108=%03d%c", 8'd1, 30, 8'd1)};
        if (v.mtype == RESEND) body = {body, $sformatf("7=%06d%c16=0%c", v.beg, 8'd1, 8'd1)};
        expBodyLen = body.len();
        msg = {$sformatf("8=FIX.4.2%c9=%03d%c", 8'd1, body.len(), 8'd1), body};
        sum = 0;
        for (int i = 0; i < msg.len(); i++) sum += int'(msg[i]);
        msg = {msg, $sformatf("10=%03d%c", sum % 256, 8'd1)};
        for (int i = 0; i < msg.len(); i++) begin
            ex.data = msg[i];
            ex.last = (i == msg.len() - 1);
            expQ.push_back(ex);
        end
    endtask

    task automatic driveRequest(input vec_t v);
        msg_type_i           = v.mtype;
        target_comp_id_i     = v.tgt;
        s_v_target_comp_id_i = v.len;
        seq_num_i            = v.seq;
        begin_seq_i          = v.beg;
        initiate_msg_i       = 1'b1;
        if (!v.expDrop) pushMessage(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        cyc = 0; firstValidCyc = -1; finalXferCyc = -100; xferCount = 0;
        doneCount = 0; dropCount = 0; sawValid = 0; sawBusy = 0;
        prevValid = 0; prevReady = 0; prevData = 0;
        curReadyMode = v.readyMode;
        driveRequest(v);
    endtask

    // One cycle of observation: drive ready, check stalls, pop scoreboard on transfers
    task automatic observeCycle();
        exp_t ex;
        @(negedge clk);
        cyc++;
        initiate_msg_i = 1'b0;
        tx_ready_i = (curReadyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (prevValid && !prevReady) begin
            checkOutput("stall_valid", 64'(tx_valid_o), 64'd1);
            checkOutput("stall_data", 64'(tx_data_o), 64'(prevData));
        end
        if (tx_valid_o) sawValid = 1;
        if (tx_valid_o && firstValidCyc < 0) firstValidCyc = cyc;
        if (busy_o) sawBusy = 1;
        if (drop_o) dropCount++;
        if (msg_done_o) begin
            doneCount++;
            checkOutput("done_timing", 64'(cyc), 64'(finalXferCyc + 1));
            checkOutput("busy_at_done", 64'(busy_o), 64'd0);
        end
        if (tx_valid_o && tx_ready_i) begin
            xferCount++;
            checkOutput("sb_has_entry", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) begin
                ex = expQ.pop_front();
                checkOutput($sformatf("byte%0d", xferCount), 64'(tx_data_o), 64'(ex.data));
                checkOutput($sformatf("last%0d", xferCount), 64'(tx_last_o), 64'(ex.last));
                if (ex.last) finalXferCyc = cyc;
            end
        end
        prevValid = tx_valid_o; prevReady = tx_ready_i; prevData = tx_data_o;
    endtask

    task automatic runTraffic(input int maxCycles, input int doneTarget, input int injectAt, input vec_t iv);
        for (int k = 0; k < maxCycles; k++) begin
            observeCycle();
            if (cyc == 1 && doneTarget > 0) checkOutput("busy_rise", 64'(busy_o), 64'd1);
            if (cyc == injectAt) driveRequest(iv);
            if (doneTarget > 0 && doneCount == doneTarget) break;
        end
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v);
        if (v.expDrop) begin
            runTraffic(30, 0, -1, v);
            checkOutput("drop_count", 64'(dropCount), 64'd1);
            checkOutput("drop_no_valid", 64'(sawValid), 64'd0);
            checkOutput("drop_no_busy", 64'(sawBusy), 64'd0);
        end else begin
            runTraffic(600, 1, -1, v);
            checkOutput("done_count", 64'(doneCount), 64'd1);
            checkOutput("sb_left", 64'(expQ.size()), 64'd0);
            checkOutput("first_valid_cyc", 64'(firstValidCyc), 64'd21);
            checkOutput("xfer_count", 64'(xferCount), 64'(23 + expBodyLen));
            if (v.readyMode == 0)
                checkOutput("occupancy", 64'(finalXferCyc - firstValidCyc + 1), 64'(23 + expBodyLen));
        end
    endtask

    initial begin
        rst = 1'b1; initiate_msg_i = 1'b0; msg_type_i = '0; target_comp_id_i = '0;
        s_v_target_comp_id_i = '0; seq_num_i = '0; begin_seq_i = '0; tx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_data", 64'(tx_data_o), 64'd0);
        checkOutput("rst_valid", 64'(tx_valid_o), 64'd0);
        checkOutput("rst_last", 64'(tx_last_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_drop", 64'(drop_o), 64'd0);
        checkOutput("rst_done", 64'(msg_done_o), 64'd0);
        rst = 1'b0;

        vecs[0]  = mkVec(HEARTBEAT, TGT_BRKR, 5'd4,  20'd1,       20'd0,       0, 1'b0);
        vecs[1]  = mkVec(LOGON,     TGT_16,   5'd16, 20'd999999,  20'd0,       0, 1'b0);
        vecs[2]  = mkVec(RESEND,    TGT_BRKR, 5'd4,  20'd7,       20'd42,      1, 1'b0);
        vecs[3]  = mkVec(RESEND,    TGT_BRKR, 5'd4,  20'd7,       20'd42,      0, 1'b0);
        vecs[4]  = mkVec(LOGOUT,    TGT_8,    5'd8,  20'd123456,  20'd0,       0, 1'b0);
        vecs[5]  = mkVec(4'hF,      TGT_BRKR, 5'd4,  20'd1,       20'd0,       0, 1'b1);
        vecs[6]  = mkVec(HEARTBEAT, TGT_BRKR, 5'd0,  20'd1,       20'd0,       0, 1'b1);
        vecs[7]  = mkVec(HEARTBEAT, TGT_BRKR, 5'd4,  20'd1000000, 20'd0,       0, 1'b1);
        vecs[8]  = mkVec(RESEND,    TGT_BRKR, 5'd4,  20'd1,       20'd1000000, 0, 1'b1);
        vecs[9]  = mkVec(HEARTBEAT, TGT_16,   5'd17, 20'd1,       20'd0,       0, 1'b1);
        vecs[10] = mkVec(RESEND,    TGT_16,   5'd16, 20'd999999,  20'd999999,  1, 1'b0);

        for (int i = 0; i < 11; i++) runVector(vecs[i]);

        // Two requests three cycles apart
        applyStimulus(mkVec(HEARTBEAT, TGT_BRKR, 5'd4, 20'd5, 20'd0, 0, 1'b0));
        inj = mkVec(LOGOUT, TGT_BRKR, 5'd4, 20'd6, 20'd0, 0, 1'b0);
`ifdef FIX_MSG_QUEUE_EN
        expDone = 2;
`else
        inj.expDrop = 1'b1;
        expDone = 1;
`endif
        runTraffic(800, expDone, 3, inj);
        checkOutput("pair_done", 64'(doneCount), 64'(expDone));
        checkOutput("pair_drop", 64'(dropCount), 64'(2 - expDone));
        checkOutput("pair_sb_left", 64'(expQ.size()), 64'd0);

        // Reset in the middle of the body, then a clean message
        applyStimulus(mkVec(HEARTBEAT, TGT_BRKR, 5'd4, 20'd77, 20'd0, 0, 1'b0));
        for (int k = 0; k < 200 && xferCount < 25; k++) observeCycle();
        checkOutput("reached_body", 64'(xferCount), 64'd25);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_valid", 64'(tx_valid_o), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy_o), 64'd0);
        checkOutput("mid_rst_last", 64'(tx_last_o), 64'd0);
        expQ.delete();
        doneCount = 0; sawValid = 0; prevValid = 0;
        for (int k = 0; k < 5; k++) observeCycle();
        checkOutput("mid_rst_no_done", 64'(doneCount), 64'd0);
        checkOutput("mid_rst_no_valid", 64'(sawValid), 64'd0);
        runVector(mkVec(HEARTBEAT, TGT_BRKR, 5'd4, 20'd78, 20'd0, 0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
